// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic light controller: phase encoding,
// lamp patterns {red,yellow,green} and default phase durations.
package traffic_pkg;

    typedef enum logic [1:0] {
        NS_GREEN  = 2'd0,
        NS_YELLOW = 2'd1,
        EW_GREEN  = 2'd2,
        EW_YELLOW = 2'd3
    } phase_t;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    localparam int unsigned DEF_GREEN_S  = 10;
    localparam int unsigned DEF_YELLOW_S = 3;

    function automatic logic is_green(input phase_t p);
        return (p == NS_GREEN) || (p == EW_GREEN);
    endfunction

endpackage

// File: rtl/traffic_light_ctrl_phase_timer.sv
// 4-bit loadable down-counter holding the seconds left in a phase.
// Counts down to 1 and stops there; expire flags the last second.
module phase_timer (
    input  logic       clk_out,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       en,
    output logic [3:0] count,
    output logic       expire
);

    always_ff @(posedge clk_out) begin
        if (load)
            count <= load_val;
        else if (en && count > 4'd1)
            count <= count - 4'd1;
    end

    assign expire = (count == 4'd1);

endmodule

// File: rtl/traffic_light_ctrl.sv
// Four-phase intersection controller with a pedestrian request that
// shortens the current green down to the yellow length.
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int unsigned GREEN_S  = DEF_GREEN_S,
    parameter int unsigned YELLOW_S = DEF_YELLOW_S
) (
    input  logic       clk_out,
    input  logic       rst,
    input  logic       en,
    input  logic       ped_req,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic [1:0] phase,
    output logic [3:0] sec_left
);

    localparam logic [3:0] GREEN_LEN  = 4'(GREEN_S);
    localparam logic [3:0] YELLOW_LEN = 4'(YELLOW_S);

    phase_t     state, state_next;
    logic       ped_pend, ped_pend_next;
    logic       ped_want;
    logic       tmr_load;
    logic [3:0] tmr_load_val;
    logic       tmr_expire;
    logic [3:0] tmr_count;

    phase_timer u_timer (
        .clk_out  (clk_out),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .en       (en),
        .count    (tmr_count),
        .expire   (tmr_expire)
    );

    always_ff @(posedge clk_out) begin
        if (rst) begin
            state    <= NS_GREEN;
            ped_pend <= 1'b0;
        end else begin
            state    <= state_next;
            ped_pend <= ped_pend_next;
        end
    end

    // A request arriving on the same edge counts immediately; any enabled
    // green cycle consumes the request, whether or not it shortened the phase.
    always_comb begin
        state_next    = state;
        ped_pend_next = ped_pend | ped_req;
        ped_want      = ped_pend | ped_req;
        tmr_load      = 1'b0;
        tmr_load_val  = GREEN_LEN;
        if (rst) begin
            tmr_load     = 1'b1;
            tmr_load_val = GREEN_LEN;
        end else if (en) begin
            if (is_green(state)) begin
                ped_pend_next = 1'b0;
                if (ped_want && tmr_count > YELLOW_LEN) begin
                    tmr_load     = 1'b1;
                    tmr_load_val = YELLOW_LEN;
                end
            end
            if (!tmr_load && tmr_expire) begin
                tmr_load     = 1'b1;
                tmr_load_val = is_green(state) ? YELLOW_LEN : GREEN_LEN;
                case (state)
                    NS_GREEN:  state_next = NS_YELLOW;
                    NS_YELLOW: state_next = EW_GREEN;
                    EW_GREEN:  state_next = EW_YELLOW;
                    default:   state_next = NS_GREEN;
                endcase
            end
        end
    end

    always_comb begin
        ns_light = LAMP_RED;
        ew_light = LAMP_RED;
        case (state)
            NS_GREEN:  ns_light = LAMP_GRN;
            NS_YELLOW: ns_light = LAMP_YEL;
            EW_GREEN:  ew_light = LAMP_GRN;
            default:   ew_light = LAMP_YEL;
        endcase
    end

    assign phase    = state;
    assign sec_left = tmr_count;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl: vector table, directed corner sequences and
// randomized traffic against a phase/seconds reference model.
module tb_traffic_light_ctrl;

    localparam int G = 10;
    localparam int Y = 3;

    logic       clk_out = 1'b0;
    logic       rst, en, ped_req;
    logic [2:0] ns_light, ew_light;
    logic [1:0] phase;
    logic [3:0] sec_left;

    int checks = 0;
    int errors = 0;

    int m_p;
    int m_left;
    bit m_pend;

    always #5 clk_out = ~clk_out;

    traffic_light_ctrl #(.GREEN_S(G), .YELLOW_S(Y)) dut (
        .clk_out  (clk_out),
        .rst      (rst),
        .en       (en),
        .ped_req  (ped_req),
        .ns_light (ns_light),
        .ew_light (ew_light),
        .phase    (phase),
        .sec_left (sec_left)
    );

    typedef struct {
        bit r;
        bit e;
        bit q;
        int p;
        int l;
    } vec_t;

    vec_t tbl[20];

    function automatic int dur(input int p);
        return (p % 2 == 0) ? G : Y;
    endfunction

    function automatic int ns_exp(input int p);
        return (p == 0) ? 1 : (p == 1) ? 2 : 4;
    endfunction

    function automatic int ew_exp(input int p);
        return (p == 2) ? 1 : (p == 3) ? 2 : 4;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic expect_out(input string name, input int p, input int l);
        check({name, ".phase"}, int'(phase), p);
        check({name, ".sec_left"}, int'(sec_left), l);
        check({name, ".ns"}, int'(ns_light), ns_exp(p));
        check({name, ".ew"}, int'(ew_light), ew_exp(p));
    endtask

    task automatic model_step(input bit r, input bit e, input bit q);
        bit green, want;
        if (r) begin
            m_p = 0; m_left = G; m_pend = 1'b0;
        end else if (!e) begin
            m_pend = m_pend | q;
        end else begin
            green = (m_p % 2 == 0);
            want  = m_pend | q;
            if (green && want && m_left > Y) begin
                m_left = Y;
                m_pend = 1'b0;
            end else begin
                if (m_left == 1) begin
                    m_p = (m_p + 1) % 4;
                    m_left = dur(m_p);
                end else begin
                    m_left = m_left - 1;
                end
                m_pend = green ? 1'b0 : want;
            end
        end
    endtask

    task automatic cyc(input bit r, input bit e, input bit q);
        bit bad;
        rst = r; en = e; ped_req = q;
        @(posedge clk_out);
        model_step(r, e, q);
        #1;
        bad = !$onehot(ns_light) || !$onehot(ew_light) ||
              (ns_light != 3'b100 && ew_light != 3'b100);
        check("lamp_exclusion", int'(bad), 0);
    endtask

    // Expected phase/seconds t cycles after reset with en held high.
    task automatic seq_exp(input int t, output int p, output int l);
        int k;
        k = t % 26;
        if (k < 10)      begin p = 0; l = 10 - k; end
        else if (k < 13) begin p = 1; l = 13 - k; end
        else if (k < 23) begin p = 2; l = 23 - k; end
        else             begin p = 3; l = 26 - k; end
    endtask

    initial begin
        int ep, el;
        rst = 1'b1; en = 1'b0; ped_req = 1'b0;

        tbl[0]  = '{1, 0, 0, 0, 10};
        tbl[1]  = '{0, 1, 0, 0, 9};
        tbl[2]  = '{0, 1, 0, 0, 8};
        tbl[3]  = '{0, 1, 1, 0, 3};
        tbl[4]  = '{0, 1, 0, 0, 2};
        tbl[5]  = '{0, 1, 0, 0, 1};
        tbl[6]  = '{0, 1, 0, 1, 3};
        tbl[7]  = '{0, 1, 0, 1, 2};
        tbl[8]  = '{0, 0, 0, 1, 2};
        tbl[9]  = '{0, 0, 1, 1, 2};
        tbl[10] = '{0, 1, 0, 1, 1};
        tbl[11] = '{0, 1, 0, 2, 10};
        tbl[12] = '{0, 1, 0, 2, 3};
        tbl[13] = '{0, 1, 0, 2, 2};
        tbl[14] = '{0, 1, 0, 2, 1};
        tbl[15] = '{0, 1, 0, 3, 3};
        tbl[16] = '{0, 1, 1, 3, 2};
        tbl[17] = '{1, 1, 1, 0, 10};
        tbl[18] = '{0, 1, 1, 0, 3};
        tbl[19] = '{1, 0, 0, 0, 10};

        for (int i = 0; i < 20; i++) begin
            cyc(tbl[i].r, tbl[i].e, tbl[i].q);
            expect_out($sformatf("vec%0d", i), tbl[i].p, tbl[i].l);
        end

        // Full free-running cycle after reset.
        cyc(1, 0, 0);
        expect_out("cycle_t0", 0, 10);
        for (int t = 1; t <= 26; t++) begin
            cyc(0, 1, 0);
            seq_exp(t, ep, el);
            expect_out($sformatf("cycle_t%0d", t), ep, el);
        end

        // Request late in green: no shortening.
        cyc(1, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 1, 0);
        expect_out("late_req_pre", 0, 2);
        cyc(0, 1, 1);
        expect_out("late_req_a", 0, 1);
        cyc(0, 1, 0);
        expect_out("late_req_b", 1, 3);
        cyc(0, 1, 0);
        expect_out("late_req_c", 1, 2);

        // Pause in EW_GREEN at sec_left 6.
        cyc(1, 0, 0);
        for (int i = 0; i < 17; i++) cyc(0, 1, 0);
        expect_out("pause_pre", 2, 6);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0);
            expect_out($sformatf("pause%0d", i), 2, 6);
        end
        cyc(0, 1, 0);
        expect_out("pause_resume", 2, 5);

        // Reset on the last second of EW_YELLOW.
        cyc(1, 0, 0);
        for (int i = 0; i < 25; i++) cyc(0, 1, 0);
        expect_out("rst_edge_pre", 3, 1);
        cyc(1, 1, 0);
        expect_out("rst_edge", 0, 10);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 99) == 0,
                $urandom_range(0, 99) < 85,
                $urandom_range(0, 99) < 8);
            expect_out("rand", m_p, m_left);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/traffic_light_ctrl.md
TRAFFIC_LIGHT_CTRL -- requirements
Module: traffic_light_ctrl

Interface
REQ-001 Parameter GREEN_S, default 10, sets the green phase length in seconds (legal range 4..15).
REQ-002 Parameter YELLOW_S, default 3, sets the yellow phase length in seconds (legal range 1..15).
REQ-003 Port clk_out, input, 1 bit: 1 s period system clock; all logic is on its rising edge.
REQ-004 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 Port en, input, 1 bit: run enable; 0 pauses the sequence.
REQ-006 Port ped_req, input, 1 bit: pedestrian crossing request, level or pulse.
REQ-007 Port ns_light, output, 3 bits: north-south lamps, one-hot {red,yellow,green}.
REQ-008 Port ew_light, output, 3 bits: east-west lamps, one-hot {red,yellow,green}.
REQ-009 Port phase, output, 2 bits: current state encoding (0 NS_GREEN, 1 NS_YELLOW, 2 EW_GREEN, 3 EW_YELLOW).
REQ-010 Port sec_left, output, 4 bits: seconds remaining in the current phase, 1..15.

Function
REQ-011 The FSM SHALL cycle NS_GREEN -> NS_YELLOW -> EW_GREEN -> EW_YELLOW -> NS_GREEN, with no other transitions.
REQ-012 On phase entry, sec_left SHALL load the phase duration (GREEN_S for greens, YELLOW_S for yellows).
REQ-013 With en=1 and sec_left>1, sec_left SHALL decrement by 1 per clock.
REQ-014 With en=1 and sec_left==1, the next edge SHALL advance the state and load the new duration, so each phase lasts exactly its duration in cycles.
REQ-015 With en=0, state, sec_left and the pending pedestrian flag SHALL hold; lamps SHALL hold their current value.
REQ-016 Lamp outputs SHALL decode from registered state only: NS_GREEN ns=001 ew=100; NS_YELLOW ns=010 ew=100; EW_GREEN ns=100 ew=001; EW_YELLOW ns=100 ew=010.
REQ-017 Both directions SHALL never show green or yellow at the same time.
REQ-018 ped_req=1 on any edge SHALL set a ped_pend flag, regardless of en.
REQ-019 In a green state with en=1, ped_pend=1 and sec_left>YELLOW_S, the next edge SHALL load sec_left=YELLOW_S instead of decrementing, and clear ped_pend.
REQ-020 In a green state with ped_pend=1 and sec_left<=YELLOW_S, the phase SHALL count normally and ped_pend SHALL clear on that edge.
REQ-021 ped_pend set during a yellow state SHALL persist until the next green, then apply REQ-019/020 on its first enabled cycle there.
REQ-022 When ped_req and a shortening event (REQ-019) coincide, the flag SHALL end cleared.
REQ-023 sec_left SHALL never read 0 and never wrap.

Reset
REQ-024 When rst=1 at an edge, the next state SHALL be NS_GREEN, with sec_left=GREEN_S, ped_pend=0, ns_light=001, ew_light=100, phase=0.
REQ-025 rst SHALL take priority over en and ped_req, including mid-phase and at the sec_left==1 boundary.

Structure
REQ-026 A shared package traffic_pkg SHALL hold the state encoding, the lamp encodings (RED=100, YEL=010, GRN=001) and the default durations.
REQ-027 A sub-module phase_timer (4-bit loadable down-counter with load, load_val, en, and an expire flag at value 1) SHALL implement sec_left; the FSM and pedestrian logic stay in traffic_light_ctrl.
REQ-028 All state SHALL be in flip-flops clocked by clk_out, with no latches and no combinational path from inputs to outputs.

Verification
REQ-029 rst for 1 cycle, then en=1 for 26 cycles -> phases 0,1,2,3 with lengths 10,3,10,3; sec_left sequence 10..1, 3..1, and so on; back to phase 0 with sec_left=10 on cycle 27.
REQ-030 ped_req pulse at NS_GREEN sec_left=8 -> next cycle sec_left=3, then 2, 1, then NS_YELLOW with sec_left=3.
REQ-031 ped_req at NS_GREEN sec_left=2 -> no shortening; sequence 2, 1, then NS_YELLOW.
REQ-032 ped_req during NS_YELLOW -> EW_GREEN entered with sec_left=10; next cycle sec_left=3.
REQ-033 en=0 for 5 cycles at EW_GREEN sec_left=6 -> all outputs frozen; after resuming, sec_left=5.
REQ-034 rst asserted at EW_YELLOW sec_left=1 with en=1 -> NS_GREEN, sec_left=10; lamp-exclusion assertion (REQ-017) checked every cycle.
